// File: rtl/seq_pkg.sv
// Shared definitions for the 10101 serial link: transmitter states and the sync header.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} tx_state_t;

    localparam int unsigned               SYNC_10101_W = 5;
    localparam logic [SYNC_10101_W-1:0]   SYNC_10101   = 5'b10101;

endpackage

// File: rtl/seq_frame_tx_10101_piso_shift.sv
// Parallel-in/serial-out shift register; the MSB is always presented on ser_o.
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] par_i,
    output logic         ser_o
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= par_i;
        end else if (shift_i) begin
            sh_q <= sh_q << 1;
        end
    end

    assign ser_o = sh_q[W-1];

endmodule

// File: rtl/seq_frame_tx_10101.sv
// Serial frame transmitter: sync header, captured payload MSB-first, then idle zeros.
module seq_frame_tx_10101 #(
    parameter int unsigned       SYNC_W = seq_pkg::SYNC_10101_W,
    parameter logic [SYNC_W-1:0] SYNC   = seq_pkg::SYNC_10101,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] payload,
    output logic              ready,
    output logic              data_out,
    output logic              busy,
    output logic              done
);

    import seq_pkg::*;

    localparam int unsigned MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_V  = (MAX_SD > GAP) ? MAX_SD : GAP;
    localparam int unsigned CW     = $clog2(MAX_V + 1);

    tx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dout_q, dout_d;
    logic            last;
    logic            pl_load, pl_shift, pl_ser;

    piso_shift #(.W(DATA_W)) u_payload (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (pl_load),
        .shift_i (pl_shift),
        .par_i   (payload),
        .ser_o   (pl_ser)
    );

    assign last = (cnt_q == '0);

    // The counter holds the index of the bit currently on the line; data_out is
    // registered, so each branch prepares the bit for the following cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = 1'b0;
        pl_load  = 1'b0;
        pl_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = seq_pkg::SYNC;
                    cnt_d   = CW'(SYNC_W - 1);
                    dout_d  = SYNC[SYNC_W-1];
                    pl_load = 1'b1;
                end
            end
            seq_pkg::SYNC: begin
                if (last) begin
                    state_d  = DATA;
                    cnt_d    = CW'(DATA_W - 1);
                    dout_d   = pl_ser;
                    pl_shift = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    for (int unsigned i = 0; i < SYNC_W; i++) begin
                        if (CW'(i + 1) == cnt_q) dout_d = SYNC[i];
                    end
                end
            end
            DATA: begin
                if (last) begin
                    state_d = seq_pkg::GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    cnt_d    = cnt_q - CW'(1);
                    dout_d   = pl_ser;
                    pl_shift = 1'b1;
                end
            end
            seq_pkg::GAP: begin
                if (!last) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (start) begin
                    state_d = seq_pkg::SYNC;
                    cnt_d   = CW'(SYNC_W - 1);
                    dout_d  = SYNC[SYNC_W-1];
                    pl_load = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == seq_pkg::GAP) && last;
    assign ready    = (state_q == IDLE) || done;

endmodule
